// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encodings,
// FSM states and the default operand width.
package muldiv_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned OP_W     = 3;
    localparam int unsigned RD_W     = 5;

    // funct3 encodings of the M extension
    localparam logic [OP_W-1:0] OP_MUL    = 3'd0;
    localparam logic [OP_W-1:0] OP_MULH   = 3'd1;
    localparam logic [OP_W-1:0] OP_MULHSU = 3'd2;
    localparam logic [OP_W-1:0] OP_MULHU  = 3'd3;
    localparam logic [OP_W-1:0] OP_DIV    = 3'd4;
    localparam logic [OP_W-1:0] OP_DIVU   = 3'd5;
    localparam logic [OP_W-1:0] OP_REM    = 3'd6;
    localparam logic [OP_W-1:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Divide/remainder ops all have funct3[2] set
    function automatic logic op_is_div(input logic [OP_W-1:0] op);
        return op[2];
    endfunction

    // Within the divide group, funct3[1] selects the remainder
    function automatic logic op_is_rem(input logic [OP_W-1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_unit_div.sv
// Unsigned restoring divider core: one quotient bit per cycle, W cycles
// after start; quotient/remainder held once done.
module div_iter
    import muldiv_pkg::*;
#(
    parameter int unsigned W = XLEN_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         done
);
    localparam int unsigned CNT_W = $clog2(W) + 1;

    logic [W-1:0]     quo_q;
    logic [W-1:0]     rem_q;
    logic [W-1:0]     dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;
    logic [W:0]       shifted;
    logic [W:0]       diff;

    // Trial subtraction of the divisor from the partial remainder
    assign shifted = {rem_q, quo_q[W-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    assign done      = run_q && (cnt_q == CNT_W'(W));
    assign quotient  = quo_q;
    assign remainder = rem_q;

    // Load on start, then shift one dividend bit in per cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q && !done) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (!diff[W]) begin
                rem_q <= diff[W-1:0];
                quo_q <= {quo_q[W-2:0], 1'b1};
            end else begin
                rem_q <= shifted[W-1:0];
                quo_q <= {quo_q[W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide execution unit. Iterative shift-add multiplier and
// restoring divider behind a valid/ready request and result handshake.
// Build option: define FAST_MUL_EN for a single-cycle multiplier on all
// MUL* ops; divides stay iterative in every build.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            wb_we,
    output logic            busy
);
    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam int unsigned PW    = 2 * XLEN;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e state, state_nxt;

    logic [2:0]       op_q;
    logic [XLEN-1:0]  rs1_q;
    logic [XLEN-1:0]  rs2_q;
    logic [XLEN-1:0]  mcand_q;
    logic [PW-1:0]    prod_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_q;
    logic             rneg_q;

    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            accept, in_is_div, div_special, in_fix, div_start;
    logic [XLEN:0]   add_sum;
    logic [PW-1:0]   prod_step, prod_fin;
    logic [XLEN-1:0] quo, rem, quo_fin, rem_fin;
    logic            div_done, calc_done;
    logic [XLEN-1:0] calc_result, fix_result;

    // Which operands are interpreted as two's complement for this op
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (in_op)
            OP_MULH, OP_DIV, OP_REM: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            OP_MULHSU: a_sgn = 1'b1;
            default: ;
        endcase
    end

    assign a_neg = a_sgn & in_rs1[XLEN-1];
    assign b_neg = b_sgn & in_rs2[XLEN-1];
    assign a_mag = a_neg ? (~in_rs1 + XLEN'(1)) : in_rs1;
    assign b_mag = b_neg ? (~in_rs2 + XLEN'(1)) : in_rs2;

    // Divide by zero and signed overflow bypass the iterative divider
    assign accept      = in_valid && in_ready;
    assign in_is_div   = op_is_div(in_op);
    assign div_special = (in_rs2 == '0)
                       || (!in_op[0] && (in_rs1 == SMIN) && (in_rs2 == '1));
`ifdef FAST_MUL_EN
    assign in_fix = in_is_div ? div_special : 1'b1;
`else
    assign in_fix = in_is_div && div_special;
`endif
    assign div_start = accept && in_is_div && !in_fix;

    div_iter #(.W(XLEN)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo),
        .remainder (rem),
        .done      (div_done)
    );

    // One shift-add multiplier step: conditional add into the high half, shift right
    assign add_sum   = {1'b0, prod_q[PW-1:XLEN]}
                     + (prod_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    assign prod_step = {add_sum, prod_q[XLEN-1:1]};
    assign calc_done = op_is_div(op_q) ? div_done : (cnt_q == CNT_W'(XLEN));

    // Sign fix-up of the magnitude results
    assign prod_fin = neg_q  ? (~prod_q + PW'(1)) : prod_q;
    assign quo_fin  = neg_q  ? (~quo + XLEN'(1))  : quo;
    assign rem_fin  = rneg_q ? (~rem + XLEN'(1))  : rem;

    // Result selection at the end of iteration
    always_comb begin
        calc_result = '0;
        if (op_is_div(op_q)) begin
            calc_result = op_is_rem(op_q) ? rem_fin : quo_fin;
        end else if (op_q == OP_MUL) begin
            calc_result = prod_fin[XLEN-1:0];
        end else begin
            calc_result = prod_fin[PW-1:XLEN];
        end
    end

`ifdef FAST_MUL_EN
    logic [PW-1:0] fast_prod, fast_fin;
    assign fast_prod = PW'(mcand_q) * PW'(prod_q[XLEN-1:0]);
    assign fast_fin  = neg_q ? (~fast_prod + PW'(1)) : fast_prod;
`endif

    // Single-cycle results: special divides, and multiplies in the fast build
    always_comb begin
        fix_result = '0;
        if (op_is_div(op_q)) begin
            if (rs2_q == '0) begin
                fix_result = op_is_rem(op_q) ? rs1_q : '1;
            end else begin
                fix_result = op_is_rem(op_q) ? '0 : rs1_q;
            end
        end else begin
`ifdef FAST_MUL_EN
            fix_result = (op_q == OP_MUL) ? fast_fin[XLEN-1:0] : fast_fin[PW-1:XLEN];
`else
            fix_result = '0;
`endif
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = in_fix ? FIX : CALC;
            end
            CALC: if (calc_done) state_nxt = DONE;
            FIX:  state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy  = !in_ready;
    assign wb_we = out_valid && out_ready && (out_rd != '0);

    // Operand capture, iteration datapath and result holding register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            mcand_q    <= '0;
            prod_q     <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q    <= in_op;
                    rs1_q   <= in_rs1;
                    rs2_q   <= in_rs2;
                    mcand_q <= a_mag;
                    prod_q  <= {{XLEN{1'b0}}, b_mag};
                    cnt_q   <= '0;
                    neg_q   <= a_neg ^ b_neg;
                    rneg_q  <= a_neg;
                    out_rd  <= in_rd;
                end
                CALC: begin
                    if (!calc_done) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (!op_is_div(op_q)) prod_q <= prod_step;
                    end else begin
                        out_result <= calc_result;
                    end
                end
                FIX: out_result <= fix_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, rd, latency, writeback
// strobe, hold behaviour, back-to-back issue and reset mid-operation.
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef FAST_MUL_EN
    localparam int ML = 1;
`else
    localparam int ML = 33;
`endif
    localparam int DL = 33;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        wb_we;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    muldiv_unit dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .wb_we      (wb_we),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Issue one op, scramble the inputs after acceptance, wait (bounded) for the
    // result, then retire it and report what was seen.
    task automatic exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output logic [4:0] ord,
                        output int lat, output logic we, output logic vld_after);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_rd = rd;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op = 3'($urandom); in_rs1 = $urandom; in_rs2 = $urandom; in_rd = 5'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_result;
        ord = out_rd;
        out_ready = 1'b1;
        #1 we = wb_we;
        @(posedge clk); #1;
        vld_after = out_valid;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        n_vec++;
        if ({in_ready, busy, out_valid, out_result, out_rd, wb_we} !== {1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got rdy=%b busy=%b vld=%b res=%h rd=%0d we=%b required 1 0 0 00000000 0 0",
                     in_ready, busy, out_valid, out_result, out_rd, wb_we);
        end
    endtask

    task automatic test_mul;
        vec_t v[8];
        logic [31:0] res; logic [4:0] ord; int lat; logic we, va;
        v[0] = '{OP_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB};
        v[1] = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'hFFFFFFFE};
        v[2] = '{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 32'h00000000};
        v[3] = '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'hFFFFFFFF};
        v[4] = '{OP_MULH,   32'h80000000, 32'h80000000, 5'd13, 32'h40000000};
        v[5] = '{OP_MULH,   32'd7,        32'hFFFFFFFD, 5'd14, 32'hFFFFFFFF};
        v[6] = '{OP_MUL,    32'h00010000, 32'h00010000, 5'd15, 32'h00000000};
        v[7] = '{OP_MULHU,  32'h00010000, 32'h00010000, 5'd16, 32'h00000001};
        foreach (v[i]) begin
            exec(v[i].op, v[i].a, v[i].b, v[i].rd, res, ord, lat, we, va);
            n_vec += 4;
            if (res !== v[i].exp) begin n_err++; $display("FAIL mul[%0d] result: got %h required %h", i, res, v[i].exp); end
            if (ord !== v[i].rd)  begin n_err++; $display("FAIL mul[%0d] rd: got %0d required %0d", i, ord, v[i].rd); end
            if (lat != ML)        begin n_err++; $display("FAIL mul[%0d] latency: got %0d required %0d", i, lat, ML); end
            if ({we, va} !== 2'b10) begin n_err++; $display("FAIL mul[%0d] wb_we/after: got %b%b required 10", i, we, va); end
        end
    endtask

    task automatic test_div;
        vec_t v[9];
        logic [31:0] res; logic [4:0] ord; int lat; logic we, va;
        v[0] = '{OP_DIV,  32'hFFFFFFF9, 32'd2,        5'd1, 32'hFFFFFFFD};
        v[1] = '{OP_REM,  32'hFFFFFFF9, 32'd2,        5'd2, 32'hFFFFFFFF};
        v[2] = '{OP_DIVU, 32'd100,      32'd7,        5'd3, 32'd14};
        v[3] = '{OP_REMU, 32'd100,      32'd7,        5'd4, 32'd2};
        v[4] = '{OP_DIV,  32'd7,        32'hFFFFFFFE, 5'd6, 32'hFFFFFFFD};
        v[5] = '{OP_REM,  32'd7,        32'hFFFFFFFE, 5'd7, 32'd1};
        v[6] = '{OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 5'd8, 32'd0};
        v[7] = '{OP_REMU, 32'h80000000, 32'hFFFFFFFF, 5'd9, 32'h80000000};
        v[8] = '{OP_DIVU, 32'hFFFFFFFF, 32'd1,        5'd17, 32'hFFFFFFFF};
        foreach (v[i]) begin
            exec(v[i].op, v[i].a, v[i].b, v[i].rd, res, ord, lat, we, va);
            n_vec += 4;
            if (res !== v[i].exp) begin n_err++; $display("FAIL div[%0d] result: got %h required %h", i, res, v[i].exp); end
            if (ord !== v[i].rd)  begin n_err++; $display("FAIL div[%0d] rd: got %0d required %0d", i, ord, v[i].rd); end
            if (lat != DL)        begin n_err++; $display("FAIL div[%0d] latency: got %0d required %0d", i, lat, DL); end
            if ({we, va} !== 2'b10) begin n_err++; $display("FAIL div[%0d] wb_we/after: got %b%b required 10", i, we, va); end
        end
    endtask

    task automatic test_div_special;
        vec_t v[6];
        logic [31:0] res; logic [4:0] ord; int lat; logic we, va;
        v[0] = '{OP_DIV,  32'd5,        32'd0,        5'd20, 32'hFFFFFFFF};
        v[1] = '{OP_REM,  32'd5,        32'd0,        5'd21, 32'd5};
        v[2] = '{OP_DIVU, 32'd5,        32'd0,        5'd22, 32'hFFFFFFFF};
        v[3] = '{OP_REMU, 32'd5,        32'd0,        5'd23, 32'd5};
        v[4] = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd24, 32'h80000000};
        v[5] = '{OP_REM,  32'h80000000, 32'hFFFFFFFF, 5'd25, 32'd0};
        foreach (v[i]) begin
            exec(v[i].op, v[i].a, v[i].b, v[i].rd, res, ord, lat, we, va);
            n_vec += 4;
            if (res !== v[i].exp) begin n_err++; $display("FAIL divspec[%0d] result: got %h required %h", i, res, v[i].exp); end
            if (ord !== v[i].rd)  begin n_err++; $display("FAIL divspec[%0d] rd: got %0d required %0d", i, ord, v[i].rd); end
            if (lat != 1)         begin n_err++; $display("FAIL divspec[%0d] latency: got %0d required 1", i, lat); end
            if ({we, va} !== 2'b10) begin n_err++; $display("FAIL divspec[%0d] wb_we/after: got %b%b required 10", i, we, va); end
        end
    endtask

    task automatic test_rd0;
        logic [31:0] res; logic [4:0] ord; int lat; logic we, va;
        exec(OP_MUL, 32'd2, 32'd3, 5'd0, res, ord, lat, we, va);
        n_vec += 3;
        if (res !== 32'd6)      begin n_err++; $display("FAIL rd0 result: got %h required 00000006", res); end
        if (ord !== 5'd0)       begin n_err++; $display("FAIL rd0 rd: got %0d required 0", ord); end
        if ({we, va} !== 2'b00) begin n_err++; $display("FAIL rd0 wb_we/after: got %b%b required 00", we, va); end
    endtask

    // Hold the result for 10 cycles, then retire while a new request waits
    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_DIVU; in_rs1 = 32'd100; in_rs2 = 32'd7; in_rd = 5'd9;
        @(posedge clk); #1;
        in_op = OP_MUL; in_rs1 = 32'd6; in_rs2 = 32'd7; in_rd = 5'd7;
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        n_vec++;
        if (lat != DL) begin n_err++; $display("FAIL hold latency: got %0d required %0d", lat, DL); end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_vec++;
            if ({out_valid, out_result, out_rd, in_ready, wb_we} !== {1'b1, 32'd14, 5'd9, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL hold[%0d]: got vld=%b res=%h rd=%0d rdy=%b we=%b required 1 0000000e 9 0 0",
                         c, out_valid, out_result, out_rd, in_ready, wb_we);
            end
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (wb_we !== 1'b1) begin n_err++; $display("FAIL hold retire wb_we: got %b required 1", wb_we); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_vec++;
        if ({out_valid, in_ready, wb_we} !== 3'b010) begin
            n_err++; $display("FAIL b2b idle: got vld/rdy/we=%b%b%b required 010", out_valid, in_ready, wb_we);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_op = OP_REMU; in_rs1 = $urandom; in_rs2 = $urandom; in_rd = 5'd31;
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b accept: got in_ready=%b required 0", in_ready); end
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        n_vec += 2;
        if (lat != ML) begin n_err++; $display("FAIL b2b latency: got %0d required %0d", lat, ML); end
        if ({out_result, out_rd} !== {32'd42, 5'd7}) begin
            n_err++; $display("FAIL b2b result: got %h rd=%0d required 0000002a rd=7", out_result, out_rd);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [31:0] res; logic [4:0] ord; int lat; logic we, va;
        logic seen;
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_DIVU; in_rs1 = 32'd1000; in_rs2 = 32'd3; in_rd = 5'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid busy: got in_ready=%b required 0", in_ready); end
        #1 reset = 1'b1;
        #1;
        n_vec++;
        if ({out_valid, in_ready, busy, wb_we, out_rd} !== {1'b0, 1'b1, 1'b0, 1'b0, 5'd0}) begin
            n_err++; $display("FAIL mid reset: got vld=%b rdy=%b busy=%b we=%b rd=%0d required 0 1 0 0 0",
                              out_valid, in_ready, busy, wb_we, out_rd);
        end
        @(negedge clk); reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid || wb_we) seen = 1'b1;
        end
        out_ready = 1'b0;
        n_vec++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL mid discard: got late result=1 required 0"); end
        exec(OP_MULHU, 32'd3, 32'd5, 5'd4, res, ord, lat, we, va);
        n_vec += 3;
        if ({res, ord} !== {32'd0, 5'd4}) begin n_err++; $display("FAIL post reset: got %h rd=%0d required 00000000 rd=4", res, ord); end
        if (lat != ML) begin n_err++; $display("FAIL post reset latency: got %0d required %0d", lat, ML); end
        if ({we, va} !== 2'b10) begin n_err++; $display("FAIL post reset wb_we/after: got %b%b required 10", we, va); end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        test_reset;
        test_mul;
        test_div;
        test_div_special;
        test_rd0;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
